// File: rtl/mlp_sgd_engine.sv
// Time-multiplexed N_IN x N_HID x 1 MLP with on-chip SGD.
// One shared MAC walks the hidden layer (h outer, i inner) and then the
// output neuron; in train mode the same sequencer walks the weights again
// to apply the gradient step. Weights live in an internal register file
// with a registered readback port.
module mlp_sgd_engine #(
  parameter int N_IN     = 4,
  parameter int N_HID    = 2,
  parameter int XW       = 4,
  parameter int WW       = 8,
  parameter int HW       = 10,
  parameter int YW       = 16,
  parameter int LR_SHIFT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic               reinit_i,
  input  logic [N_IN*XW-1:0] x_i,
  input  logic [YW-1:0]      target_i,
  input  logic [7:0]         rd_addr_i,
  output logic [WW-1:0]      rd_data_o,
  output logic [YW-1:0]      y_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               sat_o
);
  localparam int NW    = N_IN * N_HID;
  localparam int IB    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int HB    = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int WB    = (NW    > 1) ? $clog2(NW)    : 1;
  localparam int ACC_W = 40;
  localparam logic signed [ACC_W-1:0] W_MAX = ACC_W'((1 << (WW-1)) - 1);
  localparam logic signed [ACC_W-1:0] W_MIN = ~W_MAX;
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (YW-1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
  localparam logic signed [ACC_W-1:0] H_MAX = ACC_W'((1 << HW) - 1);
  localparam logic [IB-1:0] LAST_I = IB'(N_IN - 1);
  localparam logic [HB-1:0] LAST_H = HB'(N_HID - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FWD_HID, S_FWD_OUT, S_ERR, S_BWD_HID, S_BWD_OUT, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [IB-1:0] i_q, i_d;
  logic [HB-1:0] h_q, h_d;
  logic mode_q, sat_q;
  logic [XW-1:0] x_q [N_IN];
  logic [HW-1:0] hv_q [N_HID];
  logic signed [YW-1:0] target_q, y_q;
  logic signed [WW-1:0] e_q;
  logic signed [WW-1:0] w_q [NW];
  logic signed [WW-1:0] v_q [N_HID];
  logic signed [ACC_W-1:0] acc_q;
  logic [WW-1:0] rd_q, rd_d;

  logic [WB-1:0] widx;
  logic last_i, last_h, init_w, first;
  logic signed [WW-1:0] w_cur, v_cur;
  logic signed [ACC_W-1:0] x_ext, hv_ext, w_ext, v_ext, e_ext;
  logic signed [ACC_W-1:0] mac_a, mac_b, prod, acc_sum, diff, w_new, v_new;

  function automatic logic signed [WW-1:0] sat_w(input logic signed [ACC_W-1:0] a);
    if (a > W_MAX)      sat_w = W_MAX[WW-1:0];
    else if (a < W_MIN) sat_w = W_MIN[WW-1:0];
    else                sat_w = a[WW-1:0];
  endfunction

  function automatic logic ovf_w(input logic signed [ACC_W-1:0] a);
    ovf_w = (a > W_MAX) || (a < W_MIN);
  endfunction

  function automatic logic signed [YW-1:0] sat_y(input logic signed [ACC_W-1:0] a);
    if (a > Y_MAX)      sat_y = Y_MAX[YW-1:0];
    else if (a < Y_MIN) sat_y = Y_MIN[YW-1:0];
    else                sat_y = a[YW-1:0];
  endfunction

  function automatic logic ovf_y(input logic signed [ACC_W-1:0] a);
    ovf_y = (a > Y_MAX) || (a < Y_MIN);
  endfunction

  // ReLU plus upper clamp; only the upper clamp is a saturation event,
  // zeroing a negative sum is ordinary activation behaviour.
  function automatic logic [HW-1:0] clamp_h(input logic signed [ACC_W-1:0] a);
    if (a > H_MAX)             clamp_h = H_MAX[HW-1:0];
    else if (a < $signed(ACC_W'(0))) clamp_h = '0;
    else                       clamp_h = a[HW-1:0];
  endfunction

  assign last_i = (i_q == LAST_I);
  assign last_h = (h_q == LAST_H);
  assign widx   = WB'(int'(h_q) * N_IN + int'(i_q));
  assign init_w = rst_i || (state_q == S_IDLE && reinit_i && !start_i);

  // Operand selection for the shared MAC and the gradient-step arithmetic.
  always_comb begin
    w_cur   = w_q[widx];
    v_cur   = v_q[h_q];
    x_ext   = ACC_W'(x_q[i_q]);
    hv_ext  = ACC_W'(hv_q[h_q]);
    w_ext   = ACC_W'(w_cur);
    v_ext   = ACC_W'(v_cur);
    e_ext   = ACC_W'(e_q);
    first   = (state_q == S_FWD_HID) ? (i_q == '0) : (h_q == '0);
    mac_a   = (state_q == S_FWD_HID) ? x_ext : hv_ext;
    mac_b   = (state_q == S_FWD_HID) ? w_ext : v_ext;
    prod    = mac_a * mac_b;
    acc_sum = (first ? '0 : acc_q) + prod;
    diff    = ACC_W'(y_q) - ACC_W'(target_q);
    w_new   = w_ext - ((e_ext * v_ext * x_ext) >>> LR_SHIFT);
    v_new   = v_ext - ((e_ext * hv_ext) >>> LR_SHIFT);
  end

  // Sequencer next state: walks (h,i) for weight passes, h for output passes.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    h_d     = h_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_FWD_HID;
        i_d     = '0;
        h_d     = '0;
      end
      S_FWD_HID, S_BWD_HID: begin
        if (last_i) begin
          i_d = '0;
          if (last_h) begin
            h_d     = '0;
            state_d = (state_q == S_FWD_HID) ? S_FWD_OUT : S_BWD_OUT;
          end else begin
            h_d = h_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_FWD_OUT: if (last_h) begin
        h_d     = '0;
        state_d = mode_q ? S_ERR : S_DONE;
      end else begin
        h_d = h_q + 1'b1;
      end
      S_ERR: state_d = S_BWD_HID;
      S_BWD_OUT: if (last_h) begin
        h_d     = '0;
        state_d = S_DONE;
      end else begin
        h_d = h_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Readback mux: hidden weights first, then output weights, then zero.
  always_comb begin
    rd_d = '0;
    if (int'(rd_addr_i) < NW)              rd_d = w_q[WB'(rd_addr_i)];
    else if (int'(rd_addr_i) < NW + N_HID) rd_d = v_q[HB'(int'(rd_addr_i) - NW)];
  end

  // State register and sequencer counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      h_q     <= h_d;
    end
  end

  // Sample capture, forward accumulation, error and sticky saturation flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q   <= 1'b0;
      sat_q    <= 1'b0;
      target_q <= '0;
      y_q      <= '0;
      e_q      <= '0;
      acc_q    <= '0;
      rd_q     <= '0;
      for (int i = 0; i < N_IN; i++)  x_q[i]  <= '0;
      for (int h = 0; h < N_HID; h++) hv_q[h] <= '0;
    end else begin
      rd_q <= rd_d;
      case (state_q)
        S_IDLE: if (start_i) begin
          mode_q   <= mode_i;
          target_q <= target_i;
          sat_q    <= 1'b0;
          for (int i = 0; i < N_IN; i++) x_q[i] <= x_i[i*XW +: XW];
        end
        S_FWD_HID: begin
          acc_q <= acc_sum;
          if (last_i) begin
            hv_q[h_q] <= clamp_h(acc_sum);
            if (acc_sum > H_MAX) sat_q <= 1'b1;
          end
        end
        S_FWD_OUT: begin
          acc_q <= acc_sum;
          if (last_h) begin
            y_q <= sat_y(acc_sum);
            if (ovf_y(acc_sum)) sat_q <= 1'b1;
          end
        end
        S_ERR: begin
          e_q <= sat_w(diff);
          if (ovf_w(diff)) sat_q <= 1'b1;
        end
        S_BWD_HID: if (hv_q[h_q] != '0 && ovf_w(w_new)) sat_q <= 1'b1;
        S_BWD_OUT: if (ovf_w(v_new)) sat_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Weight file: init on reset/reinit, gradient step during backward passes.
  always_ff @(posedge clk_i) begin
    if (init_w) begin
      for (int h = 0; h < N_HID; h++) begin
        v_q[h] <= WW'(h + 1);
        for (int i = 0; i < N_IN; i++) w_q[h*N_IN + i] <= WW'(i + 1);
      end
    end else if (state_q == S_BWD_HID && hv_q[h_q] != '0) begin
      w_q[widx] <= sat_w(w_new);
    end else if (state_q == S_BWD_OUT) begin
      v_q[h_q] <= sat_w(v_new);
    end
  end

  assign rd_data_o = rd_q;
  assign y_o       = y_q;
  assign sat_o     = sat_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
endmodule

// File: tb/tb_mlp_sgd_engine.sv
// Bench for mlp_sgd_engine: directed scenarios plus randomized runs checked
// against an array-based reference of the network and its SGD update.
module tb_mlp_sgd_engine;
  localparam int N_IN = 4, N_HID = 2, XW = 4, WW = 8, HW = 10, YW = 16, LR_SHIFT = 4;
  localparam int NW = N_IN * N_HID;

  logic clk = 1'b0;
  logic rst, start, mode, reinit;
  logic [N_IN*XW-1:0] x;
  logic [YW-1:0] target;
  logic [7:0] rd_addr;
  logic [WW-1:0] rd_data;
  logic [YW-1:0] y;
  logic busy, done, sat;

  int checks = 0;
  int errors = 0;
  int mw [N_HID][N_IN];
  int mv [N_HID];
  int my, msat;
  int xs [N_IN];

  mlp_sgd_engine #(.N_IN(N_IN), .N_HID(N_HID), .XW(XW), .WW(WW), .HW(HW), .YW(YW),
                   .LR_SHIFT(LR_SHIFT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .reinit_i(reinit),
    .x_i(x), .target_i(target), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .y_o(y), .busy_o(busy), .done_o(done), .sat_o(sat));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int satn(input int a, input int w, inout int flag);
    int mx = (1 << (w - 1)) - 1;
    if (a > mx) begin flag = 1; return mx; end
    if (a < -mx - 1) begin flag = 1; return -mx - 1; end
    return a;
  endfunction

  task automatic model_init();
    for (int h = 0; h < N_HID; h++) begin
      mv[h] = h + 1;
      for (int i = 0; i < N_IN; i++) mw[h][i] = i + 1;
    end
  endtask

  task automatic model_run(input int tgt, input bit md);
    int hv [N_HID];
    int acc, e;
    msat = 0;
    for (int h = 0; h < N_HID; h++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) acc += xs[i] * mw[h][i];
      if (acc > (1 << HW) - 1) begin hv[h] = (1 << HW) - 1; msat = 1; end
      else if (acc < 0) hv[h] = 0;
      else hv[h] = acc;
    end
    acc = 0;
    for (int h = 0; h < N_HID; h++) acc += hv[h] * mv[h];
    my = satn(acc, YW, msat);
    if (md) begin
      e = satn(my - tgt, WW, msat);
      for (int h = 0; h < N_HID; h++)
        if (hv[h] > 0)
          for (int i = 0; i < N_IN; i++)
            mw[h][i] = satn(mw[h][i] - ((e * mv[h] * xs[i]) >>> LR_SHIFT), WW, msat);
      for (int h = 0; h < N_HID; h++)
        mv[h] = satn(mv[h] - ((e * hv[h]) >>> LR_SHIFT), WW, msat);
    end
  endtask

  task automatic check_weights(input string tag);
    int exp;
    for (int a = 0; a <= NW + N_HID; a++) begin
      @(negedge clk);
      rd_addr = 8'(a);
      @(negedge clk);
      if (a < NW) exp = mw[a / N_IN][a % N_IN];
      else if (a < NW + N_HID) exp = mv[a - NW];
      else exp = 0;
      check($sformatf("%s_rd%0d", tag, a), int'($signed(rd_data)), exp);
    end
  endtask

  task automatic do_run(input int tgt, input bit md, input string tag);
    int n;
    @(negedge clk);
    for (int i = 0; i < N_IN; i++) x[i*XW +: XW] = XW'(xs[i]);
    target = YW'(tgt);
    mode   = md;
    start  = 1'b1;
    model_run(tgt, md);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) begin start = 1'b1; reinit = 1'b1; mode = ~md; x = N_IN*XW'($urandom); end
      if (n == 5) begin start = 1'b0; reinit = 1'b0; end
    end while (!done && n < 100);
    check({tag, "_latency"}, n, md ? 2 * (NW + N_HID) + 2 : NW + N_HID + 1);
    check({tag, "_y"}, int'($signed(y)), my);
    check({tag, "_sat"}, int'(sat), msat);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; reinit = 1'b0;
    x = '0; target = '0; rd_addr = '0;
    model_init();
    my = 0; msat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_y", int'(y), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_rd", int'(rd_data), 0);
    rst = 1'b0;
    check_weights("rst");

    // T1: inference with all-ones inputs.
    for (int i = 0; i < N_IN; i++) xs[i] = 1;
    do_run(0, 1'b0, "t1");
    check("t1_y_const", int'($signed(y)), 30);
    check_weights("t1");

    // T2: training with zero error leaves weights alone.
    do_run(30, 1'b1, "t2");
    check_weights("t2");

    // T3: one real gradient step.
    do_run(14, 1'b1, "t3");
    check("t3_v0_const", mv[0], -9);
    check_weights("t3");

    // T5: reinit in IDLE restores init weights, keeps y and sat.
    @(negedge clk);
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    model_init();
    check("t5_y_kept", int'($signed(y)), my);
    check("t5_sat_kept", int'(sat), msat);
    check_weights("t5");

    // T4: large inputs force saturation everywhere.
    for (int i = 0; i < N_IN; i++) xs[i] = 15;
    do_run(0, 1'b1, "t4");
    check("t4_y_const", int'($signed(y)), 450);
    check("t4_sat_const", int'(sat), 1);
    check_weights("t4");

    // Randomized runs, with an occasional reinit to keep weights lively.
    for (int k = 0; k < 24; k++) begin
      if (k % 6 == 5) begin
        @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        model_init();
      end
      for (int i = 0; i < N_IN; i++) xs[i] = int'($urandom_range(0, (1 << XW) - 1));
      do_run(int'($urandom_range(0, 900)) - 300, 1'($urandom), $sformatf("rnd%0d", k));
      check_weights($sformatf("rnd%0d", k));
    end

    // T6: reset in the middle of a training backward pass.
    for (int i = 0; i < N_IN; i++) xs[i] = 3;
    @(negedge clk);
    for (int i = 0; i < N_IN; i++) x[i*XW +: XW] = XW'(xs[i]);
    target = YW'(5);
    mode   = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(negedge clk);
    check("t6_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_init();
    my = 0; msat = 0;
    check("t6_busy", int'(busy), 0);
    check("t6_y", int'(y), 0);
    check("t6_sat", int'(sat), 0);
    check("t6_done", int'(done), 0);
    check_weights("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
